pipe_elastic_chain: RTL and testbench

Four-stage elastic pipeline-register chain with per-stage valid bits and bubble collapsing. It is the consumer-facing end of the staged register chain used between pipeline sections: it accepts words at the head and holds them across stalls. Each stage advances independently when downstream has room. It drains in order through a valid/ready handshake at the tail and supports a synchronous flush. It also counts completed output transfers for debug.

---
 rtl/pipe_elastic_chain.sv | 113 +++++++++++
 tb/tb_pipe_elastic_chain.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_chain.sv
// rtl/pipe_elastic_chain.sv - four-stage elastic register chain with bubble collapsing
//
// Purpose: holds up to four words between a producer (head) and a consumer
// (tail). Each stage advances on its own whenever the stage below it can take
// a word, so empty stages (bubbles) are squeezed out even while the tail is
// stalled. Words drain in arrival order. A synchronous flush drops all held
// words, and a free-running counter records completed output transfers.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   head word offered
//   in_data    head word
//   in_ready   chain accepts the head word this cycle
//   out_valid  tail stage holds a word
//   out_data   tail word
//   out_ready  consumer takes the tail word this cycle
//   flush      synchronous clear of all stages
//   count      number of valid stages, 0..4
//   xfer_cnt   completed output transfers, wrapping

module pipe_elastic_chain #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [2:0]       count,
    output logic [CNTW-1:0]  xfer_cnt
);

    logic [3:0]       v;
    logic [WIDTH-1:0] d [4];

    // Ready ripples combinationally from the tail: a stage can load when it is
    // empty or when the stage below it is itself able to move.
    logic r0, r1, r2, r3;
    logic [3:0] rdy;

    assign r3  = !v[3] | out_ready;
    assign r2  = !v[2] | r3;
    assign r1  = !v[1] | r2;
    assign r0  = !v[0] | r1;
    assign rdy = {r3, r2, r1, r0};

    assign in_ready = r0 & !flush;

    // Source of each stage: S0 takes the accepted head word, Sk takes S(k-1).
    logic [3:0]       up_v;
    logic [WIDTH-1:0] up_d [4];

    assign up_v    = {v[2:0], in_valid & in_ready};
    assign up_d[0] = in_data;
    assign up_d[1] = d[0];
    assign up_d[2] = d[1];
    assign up_d[3] = d[2];

    logic [3:0] v_nxt;
    logic [2:0] count_nxt;

    always_comb begin
        v_nxt = v;
        for (int k = 0; k < 4; k++) begin
            if (rdy[k]) begin
                v_nxt[k] = up_v[k];
            end
        end
        if (flush) begin
            v_nxt = 4'b0000;
        end
    end

    // count is registered from the next-state valid bits so it always matches v.
    assign count_nxt = {2'b00, v_nxt[0]} + {2'b00, v_nxt[1]}
                     + {2'b00, v_nxt[2]} + {2'b00, v_nxt[3]};

    wire out_xfer = v[3] & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v        <= 4'b0000;
            count    <= 3'd0;
            xfer_cnt <= '0;
            for (int k = 0; k < 4; k++) begin
                d[k] <= '0;
            end
        end else begin
            v     <= v_nxt;
            count <= count_nxt;
            // Data only moves with a valid word; flush leaves data untouched.
            for (int k = 0; k < 4; k++) begin
                if (rdy[k] && up_v[k] && !flush) begin
                    d[k] <= up_d[k];
                end
            end
            // A word handed to the consumer during flush still counts.
            if (out_xfer) begin
                xfer_cnt <= xfer_cnt + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = v[3];
    assign out_data  = d[3];

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// tb/tb_pipe_elastic_chain.sv - scoreboard bench for pipe_elastic_chain

module tb_pipe_elastic_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;

    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [2:0]  count;
    logic [15:0] xfer_cnt;

    logic        w_in_ready, w_out_valid;
    logic [7:0]  w_out_data;
    logic [2:0]  w_count;
    logic [3:0]  w_xfer_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] sb[$];
    int exp_x = 0;

    always #5 clk = ~clk;

    pipe_elastic_chain #(.WIDTH(8), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush), .count(count), .xfer_cnt(xfer_cnt)
    );

    pipe_elastic_chain #(.WIDTH(8), .CNTW(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .out_valid(w_out_valid), .out_data(w_out_data),
        .out_ready(out_ready), .flush(flush), .count(w_count), .xfer_cnt(w_xfer_cnt)
    );

    // Scoreboard: inputs are stable here, so the next rising edge will perform
    // exactly the transfers visible now.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (count !== 3'(sb.size())) begin
                failures++;
                $display("FAIL sb_count: got %0d expected %0d", count, sb.size());
            end
            checks++;
            if (xfer_cnt !== 16'(exp_x)) begin
                failures++;
                $display("FAIL sb_xfer_cnt: got %0d expected %0d", xfer_cnt, exp_x);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h expected no word", out_data);
                end else begin
                    if (out_data !== sb[0]) begin
                        failures++;
                        $display("FAIL sb_data: got %h expected %h", out_data, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                exp_x++;
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    always @(negedge rst) begin
        sb.delete();
        exp_x = 0;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();
    endtask

    task automatic test_reset();
        in_valid = 1'($urandom);
        in_data = 8'($urandom);
        out_ready = 1'($urandom);
        flush = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++;
        if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL rst_xfer_cnt: got %0d expected 0", xfer_cnt); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
        cyc();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL first_accept: got %b expected 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early: edge %0d got %b expected 0", i, out_valid); end
            cyc();
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            failures++;
            $display("FAIL latency_out: got v=%b d=%h expected v=1 d=11", out_valid, out_data);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL first_xfer_cnt: got %0d expected 1", xfer_cnt); end
    endtask

    task automatic test_streaming();
        int base;
        drain();
        base = exp_x;
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready: word %0d got %b expected 1", i, in_ready); end
            if (i >= 5) begin
                checks++;
                if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_gap: word %0d got %b expected 1", i, out_valid); end
            end
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_tail_gap: cycle %0d got %b expected 1", i, out_valid); end
            cyc();
        end
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'(base + 20)) begin failures++; $display("FAIL stream_xfer_cnt: got %0d expected %0d", xfer_cnt, base + 20); end
    endtask

    task automatic test_fill_stall();
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'hA0 + 8'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_accept: word %0d got %b expected 1", i, in_ready); end
            cyc();
        end
        in_data = 8'hA4;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || count !== 3'd4) begin
                failures++;
                $display("FAIL full_stall: got in_ready=%b count=%0d expected 0 and 4", in_ready, count);
            end
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) in_data = 8'hA5;
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
            if (i < 2) begin
                checks++;
                if (in_ready !== 1'b1) begin failures++; $display("FAIL full_pass: cycle %0d got %b expected 1", i, in_ready); end
            end
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_gap: cycle %0d got %b expected 1", i, out_valid); end
            cyc();
        end
    endtask

    task automatic test_bubble();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; cyc();
        in_valid = 1'b0; repeat (2) cyc();
        in_valid = 1'b1; in_data = 8'h02; cyc();
        in_valid = 1'b0; repeat (4) cyc();
        @(negedge clk);
        checks++;
        if (count !== 3'd2 || out_valid !== 1'b1 || out_data !== 8'h01) begin
            failures++;
            $display("FAIL bubble_state: got count=%0d v=%b d=%h expected 2 1 01", count, out_valid, out_data);
        end
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bubble_adjacent: cycle %0d got %b expected 1", i, out_valid); end
            cyc();
        end
    endtask

    task automatic test_flush();
        int base;
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(i); cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        base = exp_x;
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hBF;
        @(negedge clk);
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle: got count=%0d in_ready=%b v=%b expected 3 0 1", count, in_ready, out_valid);
        end
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || xfer_cnt !== 16'(base + 1)) begin
            failures++;
            $display("FAIL flush_after: got count=%0d v=%b xfer=%0d expected 0 0 %0d", count, out_valid, xfer_cnt, base + 1);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i); cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd3) begin failures++; $display("FAIL pre_rst_count: got %0d expected 3", count); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || xfer_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_rst: got count=%0d v=%b xfer=%0d expected 0 0 0", count, out_valid, xfer_cnt);
        end
        #1 rst = 1'b1;
        cyc();
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i); cyc();
        end
        in_valid = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        checks++;
        if (w_xfer_cnt !== 4'd1) begin failures++; $display("FAIL wrap_cnt4: got %0d expected 1", w_xfer_cnt); end
        checks++;
        if (xfer_cnt !== 16'd17) begin failures++; $display("FAIL wrap_cnt16: got %0d expected 17", xfer_cnt); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_stall();
        test_bubble();
        test_flush();
        test_async_reset();
        test_wrap();
        drain();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
